udiv: RTL
=========

# udiv

Sequential unsigned restoring divider that sits directly downstream of the shift-add multiplier in the stepper speed path. It takes the 2N-bit product (e.g. clock-ticks × scale) and divides it by an N-bit speed/rate value to produce the step interval. One quotient bit is produced per clock. Start, busy and done handshake with the motion controller.

## Interface
- N, 16, denominator/remainder width; numerator and quotient are 2N bits
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; clock clk
- start  input  1  rising edge (low→high between consecutive clk edges) launches a division
- in_num  input  2N  dividend, sampled only on the launching edge
- in_den  input  N  divisor, sampled only on the launching edge
- quot  output  2N  registered quotient; reset 0
- rem  output  N  registered remainder; reset 0
- div_by_zero  output  1  registered flag for last completed operation; reset 0
- done  output  1  one-cycle pulse when quot/rem are updated; reset 0
- busy  output  1  combinational: start OR (count != 0); 0 after reset with start low

## Operation
- Edge detect: start_q registers start; start_rising = start & ~start_q. start_q resets to 0.
- Idle (count == 0) and start_rising: latch work_q = in_num, den = in_den, work_r = 0 (N+1 bits).
  - in_den != 0: count ← 2N.
  - in_den == 0: no iterations; same edge writes quot = {2N{1'b1}}, rem = in_num[N-1:0], div_by_zero = 1, done = 1.
- Iterating (count != 0), per edge:
  - t = {work_r[N-1:0], work_q[2N-1]}; work_q ← work_q << 1.
  - t >= {1'b0, den}: work_r ← t − den, work_q[0] ← 1; else work_r ← t, work_q[0] ← 0.
  - count ← count − 1.
  - Edge on which count goes 1→0 also writes quot, rem (final values including this iteration), clears div_by_zero, and sets done.
- quot/rem/div_by_zero change only on completion; they hold the previous result throughout an operation.
- start_rising while count != 0: ignored, no restart, no reload. start_q still tracks start.
- done is 0 on every edge that does not complete an operation.
- rst mid-operation: count, work regs, outputs, start_q all cleared on that edge; operation abandoned, no done. A start held high across reset release launches one division (start_q = 0 after reset).
- count width: $clog2(2N+1) bits.

## Timing
- Launch edge E0 (start_rising sampled). Nonzero divisor: iterations on E1..E2N; quot/rem valid and done high in the cycle after E2N, i.e. 2N+1 edges after E0 inclusive (33 for N=16).
- Divide by zero: results and done visible in the cycle after E0.
- Earliest relaunch: start must go low for ≥1 sampled edge, then high; a new rising edge on the same edge count reaches 0 is ignored (count still nonzero at sampling).
- No combinational path from in_num/in_den to outputs.

## Structure
- Shared package/header: UDIV_N default and UDIV_CYCLES = 2*UDIV_N, so the controller can size its timeouts.
- One sub-module: reuse the existing rising_edge_detector for start; datapath, counter and output regs live in udiv.
- No FSM encoding beyond count (0 = idle, nonzero = iterating).

## Test plan
- N=16, num=100, den=7, single start pulse → after 2N+1 edges: quot=14, rem=2, done one cycle, div_by_zero=0, busy low afterwards.
- num=0xFFFFFFFF, den=0xFFFF → quot=0x00010001, rem=0; then num=1000000, den=3 → quot=333333, rem=1.
- num=5, den=9 → quot=0, rem=5; num=0, den=1 → quot=0, rem=0.
- den=0, num=0x12345678 → next cycle quot=0xFFFFFFFF, rem=0x5678, div_by_zero=1, done pulse; following valid division clears div_by_zero.
- Launch 100/7, toggle start low→high at iteration 5 with in_num=50 → ignored; result 14 r 2, single done pulse.
- Launch 100/7, assert rst at iteration 10 → quot=rem=0, done never pulses, busy low (start low); relaunch completes normally.

Source files
------------

// File: rtl/udiv_pkg.sv
// Shared sizing for the stepper-path unsigned divider and its controller.
package udiv_pkg;

  localparam int UDIV_N      = 16;
  localparam int UDIV_CYCLES = 2 * UDIV_N;

  function automatic int udiv_cnt_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/udiv_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface udiv_if #(
  parameter int N = udiv_pkg::UDIV_N
) ();

  logic               start;
  logic [2*N-1:0]     in_num;
  logic [N-1:0]       in_den;
  logic [2*N-1:0]     quot;
  logic [N-1:0]       rem;
  logic               div_by_zero;
  logic               done;
  logic               busy;

  modport master (
    output start, in_num, in_den,
    input  quot, rem, div_by_zero, done, busy
  );

  modport slave (
    input  start, in_num, in_den,
    output quot, rem, div_by_zero, done, busy
  );

endinterface

// File: rtl/udiv_rising_edge_detector.sv
// Registers a level and flags the cycle in which it goes low to high.
module udiv_rising_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Previous-cycle copy of the level
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/udiv.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module udiv
  import udiv_pkg::*;
#(
  parameter int N = UDIV_N
) (
  input  logic   clk,
  input  logic   rst,
  udiv_if.slave  bus
);

  localparam int            CW       = udiv_cnt_w(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(2 * N);

  logic            start_rise_s;
  logic [N:0]      trial_s;

  logic [CW-1:0]   count_q, count_d;
  logic [2*N-1:0]  work_q, work_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    den_q, den_d;
  logic [2*N-1:0]  quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            done_q, done_d;

  udiv_rising_edge_detector u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (bus.start),
    .rise_o (start_rise_s)
  );

  assign trial_s = {acc_q, work_q[2*N-1]};

  // Launch, iterate and complete; count_q == 0 is the idle state
  always_comb begin
    count_d = count_q;
    work_d  = work_q;
    acc_d   = acc_q;
    den_d   = den_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    if (count_q == '0) begin
      if (start_rise_s) begin
        work_d = bus.in_num;
        den_d  = bus.in_den;
        acc_d  = '0;
        if (bus.in_den != '0) begin
          count_d = CNT_LOAD;
        end else begin
          quot_d = {(2*N){1'b1}};
          rem_d  = bus.in_num[N-1:0];
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q - CW'(1);
      // trial_s >= den guarantees the difference fits in N bits
      if (trial_s >= {1'b0, den_q}) begin
        acc_d  = trial_s[N-1:0] - den_q;
        work_d = {work_q[2*N-2:0], 1'b1};
      end else begin
        acc_d  = trial_s[N-1:0];
        work_d = {work_q[2*N-2:0], 1'b0};
      end
      if (count_q == CW'(1)) begin
        quot_d = work_d;
        rem_d  = acc_d;
        dbz_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      den_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      den_q   <= den_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = done_q;
  assign bus.busy        = bus.start | (count_q != '0);

endmodule
